// File: rtl/cpld_uart_responder.sv
// cpld_uart_responder: MMU-strobe-facing UART (8N1 TX + RX) standing in for the board CPLD.
// Latency: write strobe -> tbre low 3 clk after the falling edge; rx byte -> dataready about 9.5 bit times after the start edge.
// Backpressure: a write while tbre=0 is dropped; a full rx buffer overwrites its newest byte.
//
// Ports:
//   clk, rst          : system clock (rising edge), synchronous active-high reset
//   uart_rdn/uart_wrn : active-low read/write strobes from the MMU (asynchronous, synchronised here)
//   bus_din           : base_ram_data[7:0] as driven by the MMU (write data)
//   bus_dout, bus_oe  : read data and tri-state enable for base_ram_data[7:0]
//   uart_dataready    : rx buffer holds at least one byte
//   uart_tbre         : transmit holding register empty
//   uart_tsre         : transmit shift register empty (line idle)
//   txd, rxd          : serial line, idle high
// Build option: define UART_RX_FIFO_EN for a 4-entry rx FIFO; otherwise the rx buffer is one byte.
module cpld_uart_responder #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rdn,
  input  logic       uart_wrn,
  input  logic [7:0] bus_din,
  output logic [7:0] bus_dout,
  output logic       bus_oe,
  output logic       uart_dataready,
  output logic       uart_tbre,
  output logic       uart_tsre,
  output logic       txd,
  input  logic       rxd
);

  localparam int DIV_RAW  = CLK_FREQ / BAUD;
  localparam int BAUD_DIV = (DIV_RAW < 4) ? 4 : DIV_RAW;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] DIV_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  // ---------------------------------------------------------------------------
  // Synchronisers: [0] first flop, [1] synchronised value, [2] previous [1] for edges
  // ---------------------------------------------------------------------------
  logic [2:0] rdn_sync, wrn_sync, rxd_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdn_sync <= 3'b111;
      wrn_sync <= 3'b111;
      rxd_sync <= 3'b111;
    end else begin
      rdn_sync <= {rdn_sync[1:0], uart_rdn};
      wrn_sync <= {wrn_sync[1:0], uart_wrn};
      rxd_sync <= {rxd_sync[1:0], rxd};
    end
  end

  logic wr_fall, rd_rise, rx_fall, rx_in;
  assign wr_fall = wrn_sync[2] & ~wrn_sync[1];
  assign rd_rise = ~rdn_sync[2] & rdn_sync[1];
  assign rx_fall = rxd_sync[2] & ~rxd_sync[1];
  assign rx_in   = rxd_sync[1];

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t     tx_state, tx_state_nx;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift, tx_hold;
  logic          tbre, tsre;
  logic          tx_tick, tx_load, tx_done;

  assign tx_tick = (tx_cnt == DIV_LAST);

  always_comb begin
    tx_state_nx = tx_state;
    tx_load     = 1'b0;
    tx_done     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tbre) begin
          tx_load     = 1'b1;
          tx_state_nx = TX_START;
        end
      end
      TX_START: if (tx_tick) tx_state_nx = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_state_nx = TX_STOP;
      TX_STOP: begin
        if (tx_tick) begin
          // A byte already waiting in the holding register goes out with no idle gap.
          if (!tbre) begin
            tx_load     = 1'b1;
            tx_state_nx = TX_START;
          end else begin
            tx_done     = 1'b1;
            tx_state_nx = TX_IDLE;
          end
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_hold  <= '0;
      tbre     <= 1'b1;
      tsre     <= 1'b1;
    end else begin
      tx_cnt <= (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
      if (tx_load) begin
        tx_shift <= tx_hold;
        tx_bit   <= '0;
        tbre     <= 1'b1;
        tsre     <= 1'b0;
      end else if (tx_state == TX_DATA && tx_tick) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_bit   <= tx_bit + 1'b1;
      end
      if (tx_done) tsre <= 1'b1;
      // tx_load only fires with tbre=0, so it never competes with an accepted write.
      if (wr_fall && tbre) begin
        tx_hold <= bus_din;
        tbre    <= 1'b0;
      end
    end
  end

  always_comb begin
    txd = 1'b1;
    if (tx_state == TX_START)     txd = 1'b0;
    else if (tx_state == TX_DATA) txd = tx_shift[0];
  end

  assign uart_tbre = tbre;
  assign uart_tsre = tsre;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     rx_state, rx_state_nx;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_tick, rx_half, rx_sample, rx_push;

  assign rx_tick = (rx_cnt == DIV_LAST);
  assign rx_half = (rx_cnt == HALF_LAST);

  always_comb begin
    rx_state_nx = rx_state;
    rx_sample   = 1'b0;
    rx_push     = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_state_nx = RX_START;
      // Mid start bit: a line already back high was a glitch.
      RX_START: if (rx_half) rx_state_nx = rx_in ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (rx_tick) begin
          rx_sample = 1'b1;
          if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_push     = rx_in;  // stop bit low = framing error, byte dropped
          rx_state_nx = RX_IDLE;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      // The half-bit point re-phases the counter so data samples land mid-bit.
      if (rx_state == RX_IDLE || (rx_state == RX_START && rx_half) || rx_tick)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_IDLE) begin
        rx_bit <= '0;
      end else if (rx_sample) begin
        rx_shift <= {rx_in, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Rx buffer and read path
  // ---------------------------------------------------------------------------
  logic [7:0] rx_head;

`ifdef UART_RX_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       pop, full_hold, push_new;

  // Pop is evaluated first: a simultaneous pop frees a slot for the incoming byte.
  assign pop       = rd_rise && (count != 3'd0);
  assign full_hold = (count == 3'd4) && !pop;
  assign push_new  = rx_push && !full_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (rx_push && full_hold) begin
        fifo_mem[wr_ptr - 2'd1] <= rx_shift;  // overrun replaces the newest byte
      end else if (push_new) begin
        fifo_mem[wr_ptr] <= rx_shift;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push_new, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  assign rx_head        = fifo_mem[rd_ptr];
  assign uart_dataready = (count != 3'd0);
`else
  logic [7:0] rx_buf;
  logic       rx_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_buf  <= '0;
      rx_full <= 1'b0;
    end else if (rx_push) begin
      rx_buf  <= rx_shift;  // push wins over a same-cycle pop
      rx_full <= 1'b1;
    end else if (rd_rise) begin
      rx_full <= 1'b0;
    end
  end

  assign rx_head        = rx_buf;
  assign uart_dataready = rx_full;
`endif

  assign bus_oe   = ~rdn_sync[1];
  assign bus_dout = bus_oe ? rx_head : 8'h00;

endmodule
